// File: rtl/lsu_sequencer_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, FSM state
// type and the request legality helpers used at accept time.
package common;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } lsu_state_t;

    function automatic logic lsu_size_legal(input logic write, input logic [2:0] funct3);
        if (write) return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

    // funct3[1:0] is the access width for every legal load and store encoding.
    function automatic logic lsu_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return !addr_lo[0];
            2'b10:   return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Data-memory bus between the sequencer (master) and the memory (slave).
interface lsu_sequencer_if;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_write, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_write, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_sequencer_load_align.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
    import common::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (funct3)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     result = {24'h0, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: accepts one decoded memory op, runs the
// bus valid/ready handshake and returns extended load data to writeback.
module lsu_sequencer
    import common::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [4:0]             req_rd,
    output logic                   stall,
    lsu_sequencer_if.master        mem,
    output logic                   rsp_valid,
    output logic                   rsp_load,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic [4:0]             rsp_rd,
    output logic                   misaligned,
    output logic [31:0]            misaligned_addr
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               write_q, write_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [4:0]         rd_q, rd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_load_q, rsp_load_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic [4:0]         rsp_rd_q, rsp_rd_d;
    logic               mis_q, mis_d;
    logic [31:0]        mis_addr_q, mis_addr_d;

    logic               req_legal;
    logic               timed_out;
    logic [31:0]        load_data;
    logic [3:0]         strb;
    logic [31:0]        lane_wdata;

    lsu_load_align u_load_align (
        .rdata  (mem.mem_rdata),
        .lane   (addr_q[1:0]),
        .funct3 (size_q),
        .result (load_data)
    );

    assign req_legal = lsu_size_legal(req_write, req_size) && lsu_aligned(req_size, req_addr[1:0]);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // Expires in the TIMEOUT-th REQ/WAIT_R cycle; a handshake in that cycle still wins.
    assign timed_out = (TIMEOUT != 0) && (cnt_q >= CNT_LAST);

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rsp_valid_d = 1'b0;
        rsp_load_d  = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_rd_d    = '0;
        mis_d       = 1'b0;
        mis_addr_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_legal) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else if (req_valid) begin
                    mis_d      = 1'b1;
                    mis_addr_d = req_addr;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (mem.mem_ready) begin
                    state_d = write_q ? ST_DONE : ST_WAIT_R;
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rd_d    = rd_q;
                    end
                end else if (timed_out) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rd_d    = rd_q;
                end
            end
            ST_WAIT_R: begin
                cnt_d = cnt_inc;
                if (mem.mem_rvalid) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_load_d  = 1'b1;
                    rsp_rdata_d = load_data;
                    rsp_rd_d    = rd_q;
                end else if (timed_out) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rd_d    = rd_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rd_q    <= '0;
            mis_q       <= 1'b0;
            mis_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_load_q  <= rsp_load_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
        end
    end

    always_comb begin
        case (size_q[1:0])
            2'b00: begin
                strb       = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb       = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                strb       = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign stall           = ((state_q == ST_IDLE) && req_valid && req_legal) ||
                             (state_q == ST_REQ) || (state_q == ST_WAIT_R);

    assign mem.mem_valid   = (state_q == ST_REQ);
    assign mem.mem_write   = (state_q == ST_REQ) && write_q;
    assign mem.mem_addr    = (state_q == ST_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_wstrb   = ((state_q == ST_REQ) && write_q) ? strb : 4'h0;
    assign mem.mem_wdata   = ((state_q == ST_REQ) && write_q) ? lane_wdata : 32'h0;

    assign rsp_valid       = rsp_valid_q;
    assign rsp_load        = rsp_load_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_rd          = rsp_rd_q;
    assign misaligned      = mis_q;
    assign misaligned_addr = mis_addr_q;

endmodule
